// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter and burst sequencer that shares one byte-level SPI master
// among NUM_REQ clients. It owns the slave selects and routes TX/RX bytes per burst.
module spi_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   tx_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              tx_pop,
  output logic [NUM_REQ-1:0]              rx_valid,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic [NUM_REQ-1:0]              ss_n,
  output logic                            m_start,
  output logic [DATA_WIDTH-1:0]           m_data_in,
  input  logic                            m_done,
  input  logic [DATA_WIDTH-1:0]           m_data_out,
  output logic                            busy,
  output logic                            err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, GAP} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [IDX_W-1:0]       win_reg, win_next;
  logic [LEN_WIDTH-1:0]   rem_reg, rem_next;
  logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;
  logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;

  logic [NUM_REQ-1:0]     gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]     tx_pop_reg, tx_pop_next;
  logic [NUM_REQ-1:0]     rx_valid_reg, rx_valid_next;
  logic [DATA_WIDTH-1:0]  rx_data_reg, rx_data_next;
  logic                   m_start_reg, m_start_next;
  logic [DATA_WIDTH-1:0]  m_data_in_reg, m_data_in_next;
  logic                   busy_reg, busy_next;
  logic                   err_reg, err_next;

  logic [DATA_WIDTH-1:0]  tx_slice  [NUM_REQ];
  logic [LEN_WIDTH-1:0]   len_slice [NUM_REQ];

  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       cand;
  logic [NUM_REQ-1:0]     win_onehot_next;
  logic                   byte_done;
  logic                   timed_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign tx_slice[gi]  = tx_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign len_slice[gi] = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
    end
  endgenerate

  // First requester at or after ptr, searching upward with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(ptr_reg) + k >= NUM_REQ)
        cand = IDX_W'(int'(ptr_reg) + k - NUM_REQ);
      else
        cand = IDX_W'(int'(ptr_reg) + k);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A done pulse wins over a timeout expiring in the same cycle.
  assign byte_done = (state_reg == WAIT) && m_done;
  assign timed_out = (state_reg == WAIT) && !m_done &&
                     (to_cnt_reg == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    win_next     = win_reg;
    rem_next     = rem_reg;
    to_cnt_next  = to_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          win_next   = arb_idx;
          rem_next   = len_slice[arb_idx];
          ptr_next   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          state_next = SETUP;
        end
      end
      SETUP: state_next = START;
      START: begin
        to_cnt_next = '0;
        state_next  = WAIT;
      end
      WAIT: begin
        if (byte_done) begin
          if (rem_reg == '0) begin
            gap_cnt_next = '0;
            state_next   = GAP;
          end else begin
            rem_next   = rem_reg - LEN_WIDTH'(1);
            state_next = START;
          end
        end else if (timed_out) begin
          err_next     = 1'b1;
          gap_cnt_next = '0;
          state_next   = GAP;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1))
          state_next = IDLE;
        else
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    win_onehot_next = NUM_REQ'(1) << win_next;
    gnt_next        = '0;
    tx_pop_next     = '0;
    m_start_next    = 1'b0;
    m_data_in_next  = m_data_in_reg;
    rx_valid_next   = '0;
    rx_data_next    = rx_data_reg;
    busy_next       = (state_next != IDLE);
    if (state_next == SETUP || state_next == START || state_next == WAIT)
      gnt_next = win_onehot_next;
    if (state_next == START) begin
      m_start_next   = 1'b1;
      tx_pop_next    = win_onehot_next;
      m_data_in_next = tx_slice[win_next];
    end
    if (byte_done) begin
      rx_valid_next = NUM_REQ'(1) << win_reg;
      rx_data_next  = m_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      win_reg       <= '0;
      rem_reg       <= '0;
      to_cnt_reg    <= '0;
      gap_cnt_reg   <= '0;
      gnt_reg       <= '0;
      tx_pop_reg    <= '0;
      rx_valid_reg  <= '0;
      rx_data_reg   <= '0;
      m_start_reg   <= 1'b0;
      m_data_in_reg <= '0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      win_reg       <= win_next;
      rem_reg       <= rem_next;
      to_cnt_reg    <= to_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      gnt_reg       <= gnt_next;
      tx_pop_reg    <= tx_pop_next;
      rx_valid_reg  <= rx_valid_next;
      rx_data_reg   <= rx_data_next;
      m_start_reg   <= m_start_next;
      m_data_in_reg <= m_data_in_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  assign gnt       = gnt_reg;
  assign ss_n      = ~gnt_reg;
  assign tx_pop    = tx_pop_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;
  assign m_start   = m_start_reg;
  assign m_data_in = m_data_in_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule
